// File: rtl/stop_watch_pkg.sv
// Shared definitions for the stop_watch_gen2 stopwatch/timer.
// Contents: BCD digit limits, the {hr,min,sec} time record, the control
// state encoding and small helpers (prescaler width, digit saturation,
// binary-to-BCD conversion of the hour limit).
package stop_watch_pkg;

    localparam logic [3:0] DIGIT_MAX = 4'd9;   // units digit / hour tens limit
    localparam logic [3:0] TENS_MAX  = 4'd5;   // tens of minutes / seconds limit

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
    } sw_time_t;

    // PAUSE is IDLE with a nonzero time; no separate state is needed.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sw_state_e;

    // Bits needed to hold 0..div-1, never less than one bit.
    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Clamp one BCD digit to lim.
    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
        logic [3:0] r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Two-digit BCD form of a 0..99 integer.
    function automatic logic [7:0] to_bcd8(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX_VAL in either direction.
// Ports: clk, rst (async, active-high), clr (sync clear), en (step),
// dir (0 up / 1 down), ld + ld_val (sync load), q (digit),
// carry (stepping up from MAX_VAL), borrow (stepping down from 0).
// Priority: clr > ld > en.
module bcd_digit_cnt
    import stop_watch_pkg::*;
#(
    parameter logic [3:0] MAX_VAL = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       dir,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: clear, load, or step with wrap at the limits.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (ld) begin
            q_d = ld_val;
        end else if (en) begin
            if (dir) begin
                q_d = (q_q == 4'd0) ? MAX_VAL : (q_q - 4'd1);
            end else begin
                q_d = (q_q == MAX_VAL) ? 4'd0 : (q_q + 4'd1);
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign carry  = en & ~dir & (q_q == MAX_VAL);
    assign borrow = en & dir & (q_q == 4'd0);

endmodule

// File: rtl/bcd_hour_cnt.sv
// Two-digit BCD hour counter wrapping at HR_MAX instead of 99.
// Ports: clk_i, rst_i (async, active-high), clr_i, en_i (step from the
// minutes), dir_i (0 up / 1 down), ld_i + ld_val_i (already saturated
// preset), q_o (hours, BCD {tens,units}).
// Up from HR_MAX goes to 00; down from 00 goes to HR_MAX.
module bcd_hour_cnt
    import stop_watch_pkg::*;
#(
    parameter int HR_MAX = 99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic       ld_i,
    input  logic [7:0] ld_val_i,
    output logic [7:0] q_o
);

    localparam logic [7:0] HR_MAX_BCD = to_bcd8(HR_MAX);

    logic [7:0] hr_s;
    logic       wrap_up_s;
    logic       wrap_dn_s;
    logic       ld_any_s;
    logic       en_l_s;
    logic       en_h_s;
    logic [7:0] ld_val_s;
    logic       carry_l_s;
    logic       borrow_l_s;
    logic       unused_carry_h_s;
    logic       unused_borrow_h_s;

    assign wrap_up_s = en_i & ~dir_i & (hr_s == HR_MAX_BCD);
    assign wrap_dn_s = en_i & dir_i & (hr_s == 8'h00);
    // Wraps are realised as a load of both digits.
    assign ld_any_s  = ld_i | wrap_up_s | wrap_dn_s;
    assign en_l_s    = en_i & ~wrap_up_s & ~wrap_dn_s;
    assign en_h_s    = carry_l_s | borrow_l_s;

    // Value loaded into both digits: preset, zero on up-wrap, HR_MAX on down-wrap.
    always_comb begin
        ld_val_s = ld_val_i;
        if (ld_i) begin
            ld_val_s = ld_val_i;
        end else if (wrap_up_s) begin
            ld_val_s = 8'h00;
        end else begin
            ld_val_s = HR_MAX_BCD;
        end
    end

    bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX)) u_hr_l (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (clr_i),
        .en     (en_l_s),
        .dir    (dir_i),
        .ld     (ld_any_s),
        .ld_val (ld_val_s[3:0]),
        .q      (hr_s[3:0]),
        .carry  (carry_l_s),
        .borrow (borrow_l_s)
    );

    bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX)) u_hr_h (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (clr_i),
        .en     (en_h_s),
        .dir    (dir_i),
        .ld     (ld_any_s),
        .ld_val (ld_val_s[7:4]),
        .q      (hr_s[7:4]),
        .carry  (unused_carry_h_s),
        .borrow (unused_borrow_h_s)
    );

    assign q_o = hr_s;

endmodule

// File: rtl/stop_watch_gen2.sv
// HH:MM:SS BCD stopwatch/timer with an internal 1 s prescaler.
// Parameters: CLK_DIV (system clocks per second, >=2), HR_MAX (1..99).
// Inputs : Clk, rst (async, active-high), Clear (sync clear), start_stop
//          (rising edge toggles run/pause), cnt_down (direction, used at
//          each tick), load + ld_hr/ld_min/ld_sec (BCD preset, paused only),
//          lap (rising edge captures lap time).
// Outputs: hr_h..sec_l (BCD digits), running, tick/done/wrap (1-cycle
//          pulses), lap_hr/lap_min/lap_sec + lap_valid.
// Build option: define STOPWATCH_LAP_EN to include lap capture; without it
// the lap outputs are tied to zero and the lap input is ignored.
module stop_watch_gen2
    import stop_watch_pkg::*;
#(
    parameter int CLK_DIV = 10_000_000,
    parameter int HR_MAX  = 99
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       Clear,
    input  logic       start_stop,
    input  logic       cnt_down,
    input  logic       load,
    input  logic [7:0] ld_hr,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_sec,
    input  logic       lap,
    output logic [3:0] hr_h,
    output logic [3:0] hr_l,
    output logic [3:0] min_h,
    output logic [3:0] min_l,
    output logic [3:0] sec_h,
    output logic [3:0] sec_l,
    output logic       running,
    output logic       tick,
    output logic       done,
    output logic       wrap,
    output logic [7:0] lap_hr,
    output logic [7:0] lap_min,
    output logic [7:0] lap_sec,
    output logic       lap_valid
);

    localparam int              PW         = cnt_width(CLK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]      HR_MAX_BCD = to_bcd8(HR_MAX);

    sw_state_e     state_q;
    logic          ss_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          done_q;
    logic          wrap_q;

    sw_time_t      now_s;
    sw_time_t      ld_sat_s;
    logic [7:0]    hr_tmp_s;
    logic [7:0]    hr_s;
    logic          run_s;
    logic          ss_edge_s;
    logic          tick_s;
    logic          time_zero_s;
    logic          time_one_s;
    logic          at_top_s;
    logic          adv_s;
    logic          expire_s;
    logic          roll_s;
    logic          ld_s;

    logic sec_l_cy_s, sec_l_bw_s, sec_h_cy_s, sec_h_bw_s;
    logic min_l_cy_s, min_l_bw_s, min_h_cy_s, min_h_bw_s;

    assign now_s       = '{hr: {hr_h, hr_l}, min: {min_h, min_l}, sec: {sec_h, sec_l}};
    assign run_s       = (state_q == ST_RUN);
    assign ss_edge_s   = start_stop & ~ss_q;
    assign tick_s      = run_s & (presc_q == PRESC_LAST);
    assign time_zero_s = (now_s == 24'h00_00_00);
    assign time_one_s  = (now_s == 24'h00_00_01);
    assign at_top_s    = (now_s.hr == HR_MAX_BCD) && (now_s.min == 8'h59) && (now_s.sec == 8'h59);

    // A down-count tick at 00:00:00 (direction flipped while at zero) holds
    // the time and expires rather than wrapping to HR_MAX:59:59.
    assign adv_s    = tick_s & ~Clear & ~(cnt_down & time_zero_s);
    assign expire_s = tick_s & ~Clear & cnt_down & (time_one_s | time_zero_s);
    assign roll_s   = tick_s & ~Clear & ~cnt_down & at_top_s;
    assign ld_s     = load & ~run_s & ~Clear;

    // Saturate the preset: digits to 9, tens of min/sec to 5, hours to HR_MAX.
    always_comb begin
        ld_sat_s.sec = {sat_digit(ld_sec[7:4], TENS_MAX), sat_digit(ld_sec[3:0], DIGIT_MAX)};
        ld_sat_s.min = {sat_digit(ld_min[7:4], TENS_MAX), sat_digit(ld_min[3:0], DIGIT_MAX)};
        hr_tmp_s     = {sat_digit(ld_hr[7:4], DIGIT_MAX), sat_digit(ld_hr[3:0], DIGIT_MAX)};
        if (hr_tmp_s > HR_MAX_BCD) begin
            ld_sat_s.hr = HR_MAX_BCD;
        end else begin
            ld_sat_s.hr = hr_tmp_s;
        end
    end

    // Prescaler next value; it holds while paused so a resume finishes the partial second.
    always_comb begin
        presc_d = presc_q;
        if (Clear) begin
            presc_d = '0;
        end else if (load && !run_s) begin
            presc_d = '0;
        end else if (run_s) begin
            presc_d = tick_s ? '0 : (presc_q + PW'(1));
        end else begin
            presc_d = presc_q;
        end
    end

    // Run/pause control; a start edge ignored at zero in down mode.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Clear || load) begin
                        state_q <= ST_IDLE;
                    end else if (ss_edge_s && !(cnt_down && time_zero_s)) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (Clear || ss_edge_s || expire_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Prescaler, start edge history and the registered event pulses.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ss_q    <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ss_q    <= start_stop;
            tick_q  <= adv_s;
            done_q  <= expire_s;
            wrap_q  <= roll_s;
        end
    end

    // Seconds and minutes chain: each digit steps on its neighbour's carry/borrow.
    bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX)) u_sec_l (
        .clk(Clk), .rst(rst), .clr(Clear), .en(adv_s), .dir(cnt_down),
        .ld(ld_s), .ld_val(ld_sat_s.sec[3:0]), .q(sec_l), .carry(sec_l_cy_s), .borrow(sec_l_bw_s)
    );
    bcd_digit_cnt #(.MAX_VAL(TENS_MAX)) u_sec_h (
        .clk(Clk), .rst(rst), .clr(Clear), .en(sec_l_cy_s | sec_l_bw_s), .dir(cnt_down),
        .ld(ld_s), .ld_val(ld_sat_s.sec[7:4]), .q(sec_h), .carry(sec_h_cy_s), .borrow(sec_h_bw_s)
    );
    bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX)) u_min_l (
        .clk(Clk), .rst(rst), .clr(Clear), .en(sec_h_cy_s | sec_h_bw_s), .dir(cnt_down),
        .ld(ld_s), .ld_val(ld_sat_s.min[3:0]), .q(min_l), .carry(min_l_cy_s), .borrow(min_l_bw_s)
    );
    bcd_digit_cnt #(.MAX_VAL(TENS_MAX)) u_min_h (
        .clk(Clk), .rst(rst), .clr(Clear), .en(min_l_cy_s | min_l_bw_s), .dir(cnt_down),
        .ld(ld_s), .ld_val(ld_sat_s.min[7:4]), .q(min_h), .carry(min_h_cy_s), .borrow(min_h_bw_s)
    );
    bcd_hour_cnt #(.HR_MAX(HR_MAX)) u_hr (
        .clk_i(Clk), .rst_i(rst), .clr_i(Clear), .en_i(min_h_cy_s | min_h_bw_s), .dir_i(cnt_down),
        .ld_i(ld_s), .ld_val_i(ld_sat_s.hr), .q_o(hr_s)
    );

    assign hr_h    = hr_s[7:4];
    assign hr_l    = hr_s[3:0];
    assign running = run_s;
    assign tick    = tick_q;
    assign done    = done_q;
    assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic     lap_in_q;
    logic     lap_valid_q;
    sw_time_t lap_q;
    logic     lap_edge_s;

    assign lap_edge_s = lap & ~lap_in_q;

    // Lap capture takes the displayed time, i.e. the value before a same-cycle tick.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            lap_in_q    <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_q       <= '0;
        end else begin
            lap_in_q <= lap;
            if (Clear) begin
                lap_valid_q <= 1'b0;
                lap_q       <= '0;
            end else if (lap_edge_s) begin
                lap_valid_q <= 1'b1;
                lap_q       <= now_s;
            end else begin
                lap_valid_q <= lap_valid_q;
                lap_q       <= lap_q;
            end
        end
    end

    assign lap_hr    = lap_q.hr;
    assign lap_min   = lap_q.min;
    assign lap_sec   = lap_q.sec;
    assign lap_valid = lap_valid_q;
`else
    logic unused_lap_s;
    assign unused_lap_s = lap;
    assign lap_hr    = 8'd0;
    assign lap_min   = 8'd0;
    assign lap_sec   = 8'd0;
    assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stop_watch_gen2.sv
// Directed bench for stop_watch_gen2 with CLK_DIV=4, HR_MAX=23.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_stop_watch_gen2;

    logic       Clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       Clear      = 1'b0;
    logic       start_stop = 1'b0;
    logic       cnt_down   = 1'b0;
    logic       load       = 1'b0;
    logic [7:0] ld_hr      = 8'h00;
    logic [7:0] ld_min     = 8'h00;
    logic [7:0] ld_sec     = 8'h00;
    logic       lap        = 1'b0;
    logic [3:0] hr_h, hr_l, min_h, min_l, sec_h, sec_l;
    logic       running, tick, done, wrap, lap_valid;
    logic [7:0] lap_hr, lap_min, lap_sec;
    logic [23:0] now_s;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef STOPWATCH_LAP_EN
    localparam logic [31:0] EXP_LAP_SEC   = 32'h03;
    localparam logic [31:0] EXP_LAP_VALID = 32'd1;
`else
    localparam logic [31:0] EXP_LAP_SEC   = 32'h00;
    localparam logic [31:0] EXP_LAP_VALID = 32'd0;
`endif

    always #5 Clk = ~Clk;

    stop_watch_gen2 #(.CLK_DIV(4), .HR_MAX(23)) dut (
        .Clk(Clk), .rst(rst), .Clear(Clear), .start_stop(start_stop), .cnt_down(cnt_down),
        .load(load), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec), .lap(lap),
        .hr_h(hr_h), .hr_l(hr_l), .min_h(min_h), .min_l(min_l), .sec_h(sec_h), .sec_l(sec_l),
        .running(running), .tick(tick), .done(done), .wrap(wrap),
        .lap_hr(lap_hr), .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid)
    );

    assign now_s = {hr_h, hr_l, min_h, min_l, sec_h, sec_l};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic press();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld_hr = h; ld_min = m; ld_sec = s;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        // 1: reset, then up-count from zero
        step(3);
        check_val("rst_time", 32'(now_s), 32'h000000);
        check_val("rst_running", 32'(running), 32'd0);
        check_val("rst_flags", 32'({tick, done, wrap, lap_valid}), 32'd0);
        rst = 1'b0;
        press();
        check_val("start_running", 32'(running), 32'd1);
        step(3);
        check_val("pre_tick_time", 32'(now_s), 32'h000000);
        check_val("pre_tick_pulse", 32'(tick), 32'd0);
        step(1);
        check_val("tick1_time", 32'(now_s), 32'h000001);
        check_val("tick1_pulse", 32'(tick), 32'd1);
        step(1);
        check_val("tick1_pulse_end", 32'(tick), 32'd0);
        step(3);
        check_val("tick2_time", 32'(now_s), 32'h000002);
        press();
        check_val("pause_running", 32'(running), 32'd0);

        // 2: minute carry and full wrap
        do_load(8'h00, 8'h00, 8'h58);
        check_val("load_58", 32'(now_s), 32'h000058);
        press();
        step(4);
        check_val("up_59", 32'(now_s), 32'h000059);
        step(4);
        check_val("up_min_carry", 32'(now_s), 32'h000100);
        press();
        do_load(8'h23, 8'h59, 8'h59);
        check_val("load_top", 32'(now_s), 32'h235959);
        press();
        step(4);
        check_val("wrap_time", 32'(now_s), 32'h000000);
        check_val("wrap_pulse", 32'(wrap), 32'd1);
        check_val("wrap_running", 32'(running), 32'd1);
        step(1);
        check_val("wrap_pulse_end", 32'(wrap), 32'd0);

        // 3: pause keeps the partial second
        press();
        check_val("p3_paused", 32'(running), 32'd0);
        step(20);
        check_val("p3_hold_time", 32'(now_s), 32'h000000);
        press();
        check_val("p3_resumed", 32'(running), 32'd1);
        step(1);
        check_val("p3_no_tick_yet", 32'(now_s), 32'h000000);
        step(1);
        check_val("p3_tick_after_2", 32'(now_s), 32'h000001);
        check_val("p3_tick_pulse", 32'(tick), 32'd1);
        press();

        // 4: count down, expiry, start ignored at zero
        cnt_down = 1'b1;
        do_load(8'h00, 8'h01, 8'h01);
        press();
        step(4);
        check_val("dn_0100", 32'(now_s), 32'h000100);
        step(4);
        check_val("dn_borrow", 32'(now_s), 32'h000059);
        press();
        do_load(8'h00, 8'h00, 8'h02);
        press();
        step(4);
        check_val("dn_0001", 32'(now_s), 32'h000001);
        check_val("dn_no_done", 32'(done), 32'd0);
        step(4);
        check_val("dn_zero", 32'(now_s), 32'h000000);
        check_val("dn_done", 32'(done), 32'd1);
        check_val("dn_stopped", 32'(running), 32'd0);
        step(1);
        check_val("dn_done_end", 32'(done), 32'd0);
        press();
        check_val("dn_start_ignored", 32'(running), 32'd0);
        step(8);
        check_val("dn_zero_hold", 32'(now_s), 32'h000000);
        check_val("dn_no_done2", 32'(done), 32'd0);

        // 5: Clear beats load and start; saturated preset; load ignored while running
        cnt_down = 1'b0;
        do_load(8'h12, 8'h34, 8'h56);
        check_val("load_123456", 32'(now_s), 32'h123456);
        press();
        step(1);
        Clear = 1'b1; load = 1'b1; start_stop = 1'b1;
        ld_hr = 8'h9A; ld_min = 8'h7F; ld_sec = 8'h99;
        step(1);
        check_val("clr_prio_time", 32'(now_s), 32'h000000);
        check_val("clr_prio_running", 32'(running), 32'd0);
        Clear = 1'b0; start_stop = 1'b0;
        step(1);
        load = 1'b0;
        check_val("load_saturated", 32'(now_s), 32'h235959);
        press();
        do_load(8'h00, 8'h00, 8'h00);
        check_val("load_ignored_run", 32'(now_s), 32'h235959);
        check_val("load_ignored_state", 32'(running), 32'd1);
        press();

        // 6: lap capture, Clear, async reset mid-count
        Clear = 1'b1;
        step(1);
        Clear = 1'b0;
        press();
        step(12);
        check_val("lap_pre_time", 32'(now_s), 32'h000003);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_val("lap_sec", 32'(lap_sec), EXP_LAP_SEC);
        check_val("lap_min_hr", 32'({lap_hr, lap_min}), 32'h0000);
        check_val("lap_valid", 32'(lap_valid), EXP_LAP_VALID);
        step(3);
        check_val("lap_continues", 32'(now_s), 32'h000004);
        check_val("lap_running", 32'(running), 32'd1);
        Clear = 1'b1;
        step(1);
        Clear = 1'b0;
        check_val("clr_lap_valid", 32'(lap_valid), 32'd0);
        check_val("clr_time", 32'(now_s), 32'h000000);
        press();
        step(5);
        check_val("pre_arst_time", 32'(now_s), 32'h000001);
        rst = 1'b1;
        #2;
        check_val("arst_time", 32'(now_s), 32'h000000);
        check_val("arst_running", 32'(running), 32'd0);
        #1;
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
